// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid bit, a small skid FIFO that absorbs
// fetch responses while decode is held, N-way flush and a bubble counter.
module if_id_skid_reg #(
    parameter int                PC_W        = 32,
    parameter int                INST_W      = 32,
    parameter int                SKID_DEPTH  = 2,
    parameter int                FLUSH_SRCS  = 4,
    parameter logic [INST_W-1:0] BUBBLE_INST = '0,
    parameter int                CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [INST_W-1:0]     in_inst,
    output logic                  in_ready,
    input  logic                  stall,
    input  logic [FLUSH_SRCS-1:0] flush,
    output logic                  out_valid,
    output logic [PC_W-1:0]       out_pc,
    output logic [INST_W-1:0]     out_inst,
    output logic [2:0]            skid_count,
    output logic                  drop_err,
    output logic [CNT_W-1:0]      bubble_cnt
);

    // Storage is sized for the largest legal depth so pointers stay 2 bits
    // regardless of SKID_DEPTH; only the first SKID_DEPTH slots are used.
    localparam int         MAX_DEPTH = 4;
    localparam int         PTR_W     = 2;
    localparam logic [2:0] DEPTH_C   = 3'(SKID_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);

    logic [PC_W-1:0]   r_skid_pc   [MAX_DEPTH];
    logic [INST_W-1:0] r_skid_inst [MAX_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [2:0]        r_count;

    logic              r_out_valid;
    logic [PC_W-1:0]   r_out_pc;
    logic [INST_W-1:0] r_out_inst;
    logic              r_drop_err;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic w_ready;
    logic w_flush;
    logic w_accept;
    logic w_skid_nonempty;
    logic w_push;
    logic w_pop;
    logic w_direct;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_ready         = (r_count < DEPTH_C);
        w_flush         = |flush;
        w_accept        = in_valid & w_ready;
        w_skid_nonempty = (r_count != 3'd0);
        // Pop whenever decode advances and something is queued; an accepted
        // input goes to the skid unless the output can take it directly.
        w_pop           = !w_flush && !stall && w_skid_nonempty;
        w_push          = !w_flush && w_accept && (stall || w_skid_nonempty);
        w_direct        = !w_flush && !stall && !w_skid_nonempty && w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_skid_pc[r_tail]   <= in_pc;
            r_skid_inst[r_tail] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= next_ptr(r_tail);
            if (w_pop)  r_head <= next_ptr(r_head);
            if (w_push && !w_pop)      r_count <= r_count + 3'd1;
            else if (w_pop && !w_push) r_count <= r_count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= BUBBLE_INST;
        end else if (!stall) begin
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= r_skid_pc[r_head];
                r_out_inst  <= r_skid_inst[r_head];
            end else if (w_direct) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= in_pc;
                r_out_inst  <= in_inst;
            end else begin
                r_out_valid <= 1'b0;
                r_out_pc    <= '0;
                r_out_inst  <= BUBBLE_INST;
            end
        end
    end

    // Sticky status: neither flush nor stall touches these.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_err   <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            if (in_valid && !w_ready)
                r_drop_err <= 1'b1;
            if (!r_out_valid && !stall && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_pc;
    assign out_inst   = r_out_inst;
    assign skid_count = r_count;
    assign drop_err   = r_drop_err;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: default instance plus a CNT_W=3 instance
// sharing the same stimulus to observe bubble counter saturation.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        stall;
    logic [3:0]  flush;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  skid_count;
    logic        drop_err;
    logic [15:0] bubble_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_inst;
    logic [2:0]  s_skid_count;
    logic        s_drop_err;
    logic [2:0]  s_bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_ready(in_ready), .stall(stall), .flush(flush), .out_valid(out_valid),
        .out_pc(out_pc), .out_inst(out_inst), .skid_count(skid_count),
        .drop_err(drop_err), .bubble_cnt(bubble_cnt)
    );

    if_id_skid_reg #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_ready(s_in_ready), .stall(stall), .flush(flush), .out_valid(s_out_valid),
        .out_pc(s_out_pc), .out_inst(s_out_inst), .skid_count(s_skid_count),
        .drop_err(s_drop_err), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic s, input logic [3:0] f);
        in_valid = v;
        in_pc    = pc;
        in_inst  = {16'hC0DE, pc[15:0]};
        stall    = s;
        flush    = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [2:0] cnt);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".pc"}, 64'(out_pc), 64'(pc));
        chk({tag, ".inst"}, 64'(out_inst), v ? 64'({16'hC0DE, pc[15:0]}) : 64'h0);
        chk({tag, ".skid"}, 64'(skid_count), 64'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk_out("rst", 1'b0, 32'h0, 3'd0);
        chk("rst.drop", 64'(drop_err), 64'd0);
        chk("rst.bcnt", 64'(bubble_cnt), 64'd0);
        chk("rst.ready", 64'(in_ready), 64'd1);

        // idle cycles count bubbles; narrow counter saturates at 7
        repeat (5) step();
        chk("bcnt5", 64'(bubble_cnt), 64'd5);
        repeat (5) step();
        chk("bcnt10", 64'(bubble_cnt), 64'd10);
        chk("bcnt_sat", 64'(s_bubble_cnt), 64'd7);

        // streaming, 1-cycle latency
        drive(1'b1, 32'h100, 1'b0, 4'b0); step();
        chk_out("s100", 1'b1, 32'h100, 3'd0);
        drive(1'b1, 32'h104, 1'b0, 4'b0); step();
        chk_out("s104", 1'b1, 32'h104, 3'd0);
        drive(1'b1, 32'h108, 1'b0, 4'b0); step();
        chk_out("s108", 1'b1, 32'h108, 3'd0);
        chk("bcnt11", 64'(bubble_cnt), 64'd11);

        // skid capture under stall, then overflow
        drive(1'b1, 32'h200, 1'b0, 4'b0); step();
        chk_out("k200", 1'b1, 32'h200, 3'd0);
        drive(1'b1, 32'h204, 1'b1, 4'b0); step();
        chk_out("k204", 1'b1, 32'h200, 3'd1);
        chk("k204.ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h208, 1'b1, 4'b0); step();
        chk_out("k208", 1'b1, 32'h200, 3'd2);
        chk("k208.ready", 64'(in_ready), 64'd0);
        chk("k208.drop", 64'(drop_err), 64'd0);
        drive(1'b1, 32'h20C, 1'b1, 4'b0); step();
        chk_out("ovf", 1'b1, 32'h200, 3'd2);
        chk("ovf.drop", 64'(drop_err), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 4'b0); step();
        chk_out("pop204", 1'b1, 32'h204, 3'd1);
        step();
        chk_out("pop208", 1'b1, 32'h208, 3'd0);
        step();
        chk_out("drained", 1'b0, 32'h0, 3'd0);
        chk("drained.drop", 64'(drop_err), 64'd1);

        // simultaneous push/pop keeps count
        drive(1'b1, 32'h2F0, 1'b0, 4'b0); step();
        chk_out("p2f0", 1'b1, 32'h2F0, 3'd0);
        drive(1'b1, 32'h300, 1'b1, 4'b0); step();
        chk_out("p300", 1'b1, 32'h2F0, 3'd1);
        drive(1'b1, 32'h304, 1'b0, 4'b0); step();
        chk_out("pp", 1'b1, 32'h300, 3'd1);
        drive(1'b0, 32'h0, 1'b0, 4'b0); step();
        chk_out("pp2", 1'b1, 32'h304, 3'd0);

        // flush beats stall with a full skid
        drive(1'b1, 32'h400, 1'b0, 4'b0); step();
        drive(1'b1, 32'h404, 1'b1, 4'b0); step();
        drive(1'b1, 32'h408, 1'b1, 4'b0); step();
        chk_out("f_full", 1'b1, 32'h400, 3'd2);
        drive(1'b1, 32'h40C, 1'b1, 4'b0100); step();
        chk_out("flush", 1'b0, 32'h0, 3'd0);
        chk("flush.ready", 64'(in_ready), 64'd1);
        chk("flush.drop", 64'(drop_err), 64'd1);
        drive(1'b1, 32'h500, 1'b0, 4'b0); step();
        chk_out("post_flush", 1'b1, 32'h500, 3'd0);
        chk("bcnt13", 64'(bubble_cnt), 64'd13);

        // reset mid-operation beats pending skid and flush
        drive(1'b1, 32'h504, 1'b1, 4'b0); step();
        chk_out("pre_rst", 1'b1, 32'h500, 3'd1);
        rst = 1'b1;
        drive(1'b1, 32'h508, 1'b0, 4'b0001); step();
        rst = 1'b0;
        chk_out("mid_rst", 1'b0, 32'h0, 3'd0);
        chk("mid_rst.drop", 64'(drop_err), 64'd0);
        chk("mid_rst.bcnt", 64'(bubble_cnt), 64'd0);
        chk("mid_rst.sbcnt", 64'(s_bubble_cnt), 64'd0);
        drive(1'b1, 32'h600, 1'b0, 4'b0); step();
        chk_out("after_rst", 1'b1, 32'h600, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline register. Successor to the fixed 32-bit fetch/decode latch.
- Adds a valid bit, a small skid FIFO that catches fetch responses arriving while decode is held, and an N-way flush vector.
- Adds a saturating bubble counter for performance monitoring.
- Sits between the fetch unit (instruction memory response) and the decode stage.

Parameters:
- PC_W, 32, program counter width.
- INST_W, 32, instruction width.
- SKID_DEPTH, 2, skid FIFO entries; legal range 1..4.
- FLUSH_SRCS, 4, number of flush request inputs (branch, wfi, interrupt entry, interrupt return).
- BUBBLE_INST, 32'h0000_0000, instruction value driven on out_inst for bubbles; width INST_W.
- CNT_W, 16, bubble counter width.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, fetch presents in_pc/in_inst this cycle.
- in_pc, input, PC_W, fetched PC.
- in_inst, input, INST_W, fetched instruction.
- in_ready, output, 1, block can accept the input this cycle.
- stall, input, 1, decode hold (hazard or downstream memory wait); output register must not change.
- flush, input, FLUSH_SRCS, any set bit squashes all held state.
- out_valid, output, 1, out_pc/out_inst hold a real instruction.
- out_pc, output, PC_W, registered PC to decode.
- out_inst, output, INST_W, registered instruction to decode.
- skid_count, output, 3, number of occupied skid entries.
- drop_err, output, 1, sticky; set when in_valid=1 while in_ready=0.
- bubble_cnt, output, CNT_W, saturating count of cycles with out_valid=0 and stall=0.

Behaviour:
- All outputs are registered except in_ready.
- Reset values: out_valid=0, out_pc=0, out_inst=BUBBLE_INST, skid empty, skid_count=0, drop_err=0, bubble_cnt=0.
- in_ready = (skid_count < SKID_DEPTH). It depends on state only, never on stall or flush.
- An input is accepted when in_valid & in_ready.
- Update priority each cycle: rst > flush > stall > advance.
- Flush (|flush=1, regardless of stall):
  - Output register becomes a bubble: out_valid=0, out_pc=0, out_inst=BUBBLE_INST.
  - skid_count=0.
  - Any input accepted that cycle is discarded.
  - drop_err and bubble_cnt are unaffected.
- Stall (stall=1, no flush):
  - Output register holds its value.
  - An accepted input is pushed to the skid tail.
- Advance (stall=0, no flush), output register loads in this order:
  - Skid head (pop), if skid_count > 0. An accepted input is pushed in the same cycle, so count is unchanged.
  - Otherwise the accepted input: out_valid=1, out_pc=in_pc, out_inst=in_inst. Latency is 1 cycle.
  - Otherwise a bubble.
- Skid FIFO:
  - Circular buffer with head/tail pointers that wrap modulo SKID_DEPTH.
  - Order is strictly FIFO.
  - A push and a pop in the same cycle when full is impossible, because in_ready=0 when full.
- drop_err:
  - Set on any cycle with in_valid=1 and in_ready=0.
  - The input is ignored.
  - Cleared only by rst.
- bubble_cnt:
  - Increments on cycles where out_valid=0 and stall=0, using the current register value.
  - Saturates at all-ones.
  - Cleared only by rst.
- Reset asserted mid-operation wins over everything, including pending skid entries and a simultaneous flush.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 with pc 0x100, 0x104, 0x108 on successive cycles, stall=0 → out_pc 0x100/0x104/0x108 one cycle later, out_valid=1, skid_count=0.
- Skid capture: out holds pc 0x200, stall=1 for 3 cycles, fetch delivers 0x204 then 0x208 → out holds 0x200; skid_count 1, then 2; in_ready=0 in the third cycle. Releasing stall gives out 0x204, then 0x208; skid_count back to 0.
- Overflow: with SKID_DEPTH=2 and skid full, assert in_valid with pc 0x20C → drop_err=1 and stays 1 until rst; 0x20C never appears on out_pc.
- Flush beats stall: stall=1, skid_count=2, flush=4'b0100 with in_valid=1 → next cycle out_valid=0, out_inst=BUBBLE_INST, out_pc=0, skid_count=0, in_ready=1.
- Bubble counter: in_valid=0 and stall=0 for 5 cycles after reset → bubble_cnt=5. With CNT_W=3, 10 idle cycles → bubble_cnt stays at 7.
- Simultaneous push/pop: skid_count=1 (pc 0x300), stall=0, in_valid=1 with pc 0x304 → out_pc=0x300, skid_count stays 1; next cycle out_pc=0x304.
